// File: rtl/pico_pkg.sv
// rtl/pico_pkg.sv - shared opcodes, states, field slices and ALU codes for the picoMIPS sequencer
package pico_pkg;

    // Instruction field positions: [16:14] opcode, [13:11] %d, [10:8] %s, [7:0] imm
    localparam int OP_MSB  = 16;
    localparam int OP_LSB  = 14;
    localparam int D_MSB   = 13;
    localparam int D_LSB   = 11;
    localparam int S_MSB   = 10;
    localparam int S_LSB   = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_SUB  = 3'b011,
        OP_SUBI = 3'b100,
        OP_MULI = 3'b101,
        OP_BEQ  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // ALU function code set shared with the datapath ALU
    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_MUL = 3'd3;

    // Registers that must never be written: %0 zero, %5 SW[7:0], %6 SW8, %7 reserved
    localparam logic [7:0] RO_REGS = 8'b1110_0001;

endpackage

// File: rtl/pico_decode.sv
// rtl/pico_decode.sv - combinational opcode decode into ALU controls and instruction class
module pico_decode
    import pico_pkg::*;
(
    input  logic [2:0] opcode,
    output logic [2:0] func,
    output logic       use_imm,
    output logic       is_write,
    output logic       is_branch,
    output logic       is_halt
);

    // Map each opcode to its ALU function, B-operand source and class flags
    always_comb begin
        func      = ALU_NOP;
        use_imm   = 1'b0;
        is_write  = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        case (opcode_t'(opcode))
            OP_ADD:  begin func = ALU_ADD; is_write = 1'b1; end
            OP_ADDI: begin func = ALU_ADD; use_imm = 1'b1; is_write = 1'b1; end
            OP_SUB:  begin func = ALU_SUB; is_write = 1'b1; end
            OP_SUBI: begin func = ALU_SUB; use_imm = 1'b1; is_write = 1'b1; end
            OP_MULI: begin func = ALU_MUL; use_imm = 1'b1; is_write = 1'b1; end
            OP_BEQ:  is_branch = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pico_seq.sv
// rtl/pico_seq.sv - multi-cycle fetch/decode/exec/writeback sequencer for the picoMIPS core
module pico_seq
    import pico_pkg::*;
#(
    parameter int PCW = 6,
    parameter int IW  = 17
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  instr,
    input  logic           eq,
    output logic [PCW-1:0] pc,
    output logic [2:0]     Raddr1,
    output logic [2:0]     Raddr2,
    output logic           w,
    output logic [7:0]     imm,
    output logic           use_imm,
    output logic [2:0]     func,
    output logic           halted,
    output logic           wr_err
);

    state_t         state;
    state_t         next_state;
    logic [IW-1:0]  ir;
    logic [IW-1:0]  dec_src;
    logic [2:0]     dec_func;
    logic           dec_use_imm;
    logic           dec_write;
    logic           dec_branch;
    logic           dec_halt;
    logic           dst_ro;
    logic [15:0]    off_sext;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] pc_branch;

    // In DECODE the ROM word is not yet in ir, so decode it straight from the ROM
    // to have registered controls valid for the whole EXEC cycle.
    assign dec_src   = (state == ST_DECODE) ? instr : ir;
    assign dst_ro    = RO_REGS[ir[D_MSB:D_LSB]];
    assign off_sext  = {{8{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    assign pc_inc    = pc + PCW'(1);
    // Only the low PCW bits of the sign-extended offset matter: wrap is modulo 2^PCW
    assign pc_branch = pc_inc + off_sext[PCW-1:0];

    pico_decode u_decode (
        .opcode    (dec_src[OP_MSB:OP_LSB]),
        .func      (dec_func),
        .use_imm   (dec_use_imm),
        .is_write  (dec_write),
        .is_branch (dec_branch),
        .is_halt   (dec_halt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_FETCH;
        else       state <= next_state;
    end

    // Next-state sequencing; HALT absorbs until reset
    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                if (dec_halt)       next_state = ST_HALT;
                else if (dec_write) next_state = ST_WB;
                else                next_state = ST_FETCH;
            end
            ST_WB:     next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_FETCH;
        endcase
    end

    // Registered datapath controls, PC update and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            Raddr1  <= '0;
            Raddr2  <= '0;
            w       <= 1'b0;
            imm     <= '0;
            use_imm <= 1'b0;
            func    <= ALU_NOP;
            halted  <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            case (state)
                ST_DECODE: begin
                    ir      <= instr;
                    Raddr1  <= instr[S_MSB:S_LSB];
                    Raddr2  <= instr[D_MSB:D_LSB];
                    imm     <= instr[IMM_MSB:IMM_LSB];
                    func    <= dec_func;
                    use_imm <= dec_use_imm;
                end
                ST_EXEC: begin
                    if (dec_halt) begin
                        halted <= 1'b1;
                    end else if (dec_write) begin
                        // Protected destination: suppress the strobe, flag it, still advance in WB
                        if (dst_ro) wr_err <= 1'b1;
                        else        w      <= 1'b1;
                    end else if (dec_branch && eq) begin
                        pc <= pc_branch;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                ST_WB: begin
                    w  <= 1'b0;
                    pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pico_seq.md
Name: pico_seq

Overview:
Multi-cycle control sequencer for the picoMIPS core. It fetches instructions from a synchronous program ROM and decodes them. It then sequences the register file read addresses, the ALU function/immediate selection and the register-file write strobe, and maintains the PC, including the BEQ relative branch. It sits between the program ROM and the regs/ALU datapath. It is the sole driver of regs.w, regs.Raddr1 and regs.Raddr2.

Parameters:
PCW, 6, program counter / ROM address width
IW, 17, instruction width: [16:14] opcode, [13:11] %d, [10:8] %s, [7:0] imm

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr  in  IW  ROM data; valid one cycle after pc is presented
eq  in  1  datapath compare, Rdata1 == Rdata2, combinational from regs
pc  out  PCW  ROM address
Raddr1  out  3  source register %s
Raddr2  out  3  destination register %d (also the second compare operand)
w  out  1  register-file write enable
imm  out  8  immediate to ALU B-mux
use_imm  out  1  1 = ALU B operand is imm, 0 = Rdata2
func  out  3  ALU function code, from the shared alu code set
halted  out  1  HALT executed
wr_err  out  1  sticky: write to a read-only register was suppressed

Behaviour:
- Reset (clk edge with reset=1):
  - pc=0, state=FETCH, ir=0.
  - w=0, Raddr1=Raddr2=0, imm=0, use_imm=0, func=ALU_NOP.
  - halted=0, wr_err=0.
  - Reset mid-instruction aborts the instruction: no write occurs and the PC is not updated.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH. HALT is absorbing until reset.
  - FETCH: pc is presented to the ROM.
  - DECODE: ir <= instr.
  - EXEC: drive Raddr1=ir.s, Raddr2=ir.d, func, use_imm, imm from ir. Sample eq on the EXEC->next edge.
  - WB: hold addresses and func; w=1 for write-class ops; pc <= pc+1.
- Opcodes:
  - 000 NOP: EXEC -> FETCH, pc+1, no write.
  - 001 ADD (use_imm=0), 010 ADDI, 011 SUB (use_imm=0), 100 SUBI, 101 MULI (fractional, imm/256; e.g. 0xC0 = 0.75): write-class.
  - 110 BEQ %d,%s,off: EXEC -> FETCH. If eq=1, pc <= pc+1+sext(imm); else pc <= pc+1. No write.
  - 111 HALT: EXEC -> HALT, pc frozen, halted=1.
- Latency: write-class ops take 4 cycles; NOP and BEQ take 3 cycles.
- Outputs are registered and change only on clock edges. w is high for exactly one cycle (WB) per write-class instruction.
- Write protection:
  - %d in {0,5,6,7} (zero, SW[7:0], SW8, reserved) on a write-class op: w stays 0, wr_err <= 1 (sticky until reset), pc still advances.
  - %d = 4 (LED) is writable.
- Branch arithmetic is modulo 2^PCW. BEQ off=-1 (0xFF) targets itself, forming a busy-wait loop. PC wraps from 2^PCW-1 to 0 silently.
- The BEQ compare always uses Raddr1=ir.s and Raddr2=ir.d. eq must settle within EXEC; it is sampled once per BEQ.

Decomposition:
- Shared package pico_pkg:
  - opcode enum (OP_NOP..OP_HALT).
  - state enum.
  - instruction field slice localparams.
  - ALU function codes (reuse the existing alu code definitions; no new copies).
  - read-only register set constant.
- Optional sub-module pico_decode: combinational ir -> {func, use_imm, is_write, is_branch, is_halt}. This keeps the FSM small and the decode table unit-testable.

Test Plan:
- Reset then run instruction ADDI %4,%1,20 (opcode 010, d=4, s=1, imm=0x14) at pc=0 -> w=1 only in cycle 4 with Raddr1=1, Raddr2=4, use_imm=1, imm=0x14, func=ADD; pc=1 after WB.
- BEQ %0,%6,-1 at pc=3 with eq=0 -> pc=4 after 3 cycles; with eq=1 held -> pc stays 3 every 3 cycles, w never asserted.
- MULI %1,%5,0xC0 -> Raddr1=5, Raddr2=1, imm=0xC0, func=MUL, one w pulse; ADD %2,%1 -> use_imm=0.
- ADDI %5,%1,1 -> w=0 throughout, wr_err=1 from WB onward, pc advances; a later legal write still pulses w.
- pc=2^PCW-1 executing NOP -> pc=0; BEQ at pc=0 with off=-2 and eq=1 -> pc=2^PCW-1.
- HALT -> halted=1, pc frozen, w=0 for 20 cycles. Assert reset during WB of an ADDI -> no w pulse, pc=0, state FETCH next cycle.
